// File: rtl/calc_entry_fsm.sv
// Keypad entry controller: builds two packed-BCD operands and an operator from key events.
// Outputs are registered and change on the edge that detects a key press, one clock after btn_press rises.
// There is no backpressure. A held key gives one event. CALC_ENTRY_TIMEOUT_EN adds an idle auto-clear.
module calc_entry_fsm #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_press,
  input  logic                    is_num,
  input  logic                    is_op,
  input  logic                    is_eq,
  input  logic [3:0]              num_val,
  input  logic [1:0]              op_val,
  input  logic [4*NUM_DIGITS-1:0] alu_result,
  output logic [4*NUM_DIGITS-1:0] num1_bcd,
  output logic [4*NUM_DIGITS-1:0] num2_bcd,
  output logic [1:0]              operation,
  output logic [1:0]              curr_state,
  output logic                    key_ack
);

  localparam int NW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_NUM1   = 2'b00,
    S_OP     = 2'b01,
    S_NUM2   = 2'b10,
    S_RESULT = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] num1_q, num1_d, num2_q, num2_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic          btn_q, btn_d, holdoff_q, holdoff_d, ack_q, ack_d;
  logic          evt, digit_evt, op_evt, eq_evt;

`ifdef CALC_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_fire;
`endif

  // holdoff blocks a key still held from before reset until it is seen released
  assign evt       = btn_press & ~btn_q & ~holdoff_q;
  assign digit_evt = evt & is_num & (num_val <= 4'd9);
  assign op_evt    = evt & ~is_num & is_op;
  assign eq_evt    = evt & ~is_num & ~is_op & is_eq;

  always_comb begin
    state_d   = state_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    op_d      = op_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    btn_d     = btn_press;
    holdoff_d = holdoff_q & btn_press;
    ack_d     = 1'b0;
    case (state_q)
      S_NUM1: begin
        if (digit_evt && cnt1_q != FULL) begin
          num1_d = {num1_q[NW-5:0], num_val};
          cnt1_d = cnt1_q + 1'b1;
          ack_d  = 1'b1;
        end else if (op_evt) begin
          op_d    = op_val;
          num2_d  = '0;
          cnt2_d  = '0;
          state_d = S_OP;
          ack_d   = 1'b1;
        end
      end
      S_OP: begin
        if (digit_evt) begin
          num2_d  = NW'(num_val);
          cnt2_d  = CW'(1);
          state_d = S_NUM2;
          ack_d   = 1'b1;
        end else if (op_evt) begin
          op_d  = op_val;
          ack_d = 1'b1;
        end
      end
      S_NUM2: begin
        if (digit_evt && cnt2_q != FULL) begin
          num2_d = {num2_q[NW-5:0], num_val};
          cnt2_d = cnt2_q + 1'b1;
          ack_d  = 1'b1;
        end else if (eq_evt) begin
          state_d = S_RESULT;
          ack_d   = 1'b1;
        end
      end
      default: begin
        if (digit_evt) begin
          num1_d  = NW'(num_val);
          cnt1_d  = CW'(1);
          num2_d  = '0;
          cnt2_d  = '0;
          op_d    = 2'b00;
          state_d = S_NUM1;
          ack_d   = 1'b1;
        end else if (op_evt) begin
          // chain the previous result in as a complete first operand
          num1_d  = alu_result;
          cnt1_d  = FULL;
          num2_d  = '0;
          cnt2_d  = '0;
          op_d    = op_val;
          state_d = S_OP;
          ack_d   = 1'b1;
        end
      end
    endcase
`ifdef CALC_ENTRY_TIMEOUT_EN
    tmo_fire = (tmo_q == TMO_MAX) && (state_q != S_NUM1 || cnt1_q != '0);
    if (ack_d)
      tmo_d = '0;
    else if (tmo_q == TMO_MAX)
      tmo_d = tmo_q;
    else
      tmo_d = tmo_q + 1'b1;
    if (tmo_fire) begin
      state_d   = S_NUM1;
      num1_d    = '0;
      num2_d    = '0;
      op_d      = 2'b00;
      cnt1_d    = '0;
      cnt2_d    = '0;
      btn_d     = 1'b0;
      holdoff_d = 1'b1;
      ack_d     = 1'b0;
      tmo_d     = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_NUM1;
      num1_q    <= '0;
      num2_q    <= '0;
      op_q      <= 2'b00;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      btn_q     <= 1'b0;
      holdoff_q <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      op_q      <= op_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      btn_q     <= btn_d;
      holdoff_q <= holdoff_d;
      ack_q     <= ack_d;
    end
  end

`ifdef CALC_ENTRY_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

  assign num1_bcd   = num1_q;
  assign num2_bcd   = num2_q;
  assign operation  = op_q;
  assign curr_state = state_q;
  assign key_ack    = ack_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scoreboard bench for calc_entry_fsm: each accepted key pushes its expected outputs, a monitor checks on key_ack.
module tb_calc_entry_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_press = 1'b0, is_num = 1'b0, is_op = 1'b0, is_eq = 1'b0;
  logic [3:0]  num_val = 4'd0;
  logic [1:0]  op_val = 2'd0;
  logic [15:0] alu_result = 16'h0042;
  logic [15:0] num1_bcd, num2_bcd;
  logic [1:0]  operation, curr_state;
  logic        key_ack;

  typedef struct {
    int          cyc;
    logic [15:0] n1;
    logic [15:0] n2;
    logic [1:0]  op;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  calc_entry_fsm #(.NUM_DIGITS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .btn_press(btn_press), .is_num(is_num), .is_op(is_op),
    .is_eq(is_eq), .num_val(num_val), .op_val(op_val), .alu_result(alu_result),
    .num1_bcd(num1_bcd), .num2_bcd(num2_bcd), .operation(operation),
    .curr_state(curr_state), .key_ack(key_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // checks {num1, num2, operation, curr_state, key_ack}
  task automatic chk_out(input string nm, input logic [15:0] n1, input logic [15:0] n2,
                         input logic [1:0] op, input logic [1:0] st);
    chk(nm, {num1_bcd, num2_bcd, operation, curr_state, key_ack}, {n1, n2, op, st, 1'b0});
  endtask

  // monitor: every key_ack must match the oldest outstanding expectation, one clock after the press
  always @(negedge clk) begin
    if (rst && key_ack) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack at cycle %0d with n1=%h st=%b expected none",
                 cyc, num1_bcd, curr_state);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("ack_outputs", {num1_bcd, num2_bcd, operation, curr_state}, {e.n1, e.n2, e.op, e.st});
      end
    end
  end

  task automatic push_exp(input logic [15:0] n1, input logic [15:0] n2,
                          input logic [1:0] op, input logic [1:0] st);
    exp_t e;
    e.cyc = cyc + 1;
    e.n1 = n1; e.n2 = n2; e.op = op; e.st = st;
    sb.push_back(e);
  endtask

  task automatic press(input logic n, input logic o, input logic q, input logic [3:0] nv,
                       input logic [1:0] ov, input bit ack, input logic [15:0] x1,
                       input logic [15:0] x2, input logic [1:0] xop, input logic [1:0] xst);
    @(negedge clk);
    is_num = n; is_op = o; is_eq = q; num_val = nv; op_val = ov;
    btn_press = 1'b1;
    if (ack) push_exp(x1, x2, xop, xst);
    repeat (3) @(negedge clk);
    btn_press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_out("reset_state", 16'h0, 16'h0, 2'b00, 2'b00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    press(1, 0, 0, 4'd1, 2'd0, 1, 16'h0001, 16'h0, 2'b00, 2'b00);
    press(1, 0, 0, 4'd2, 2'd0, 1, 16'h0012, 16'h0, 2'b00, 2'b00);
    press(1, 0, 0, 4'd3, 2'd0, 1, 16'h0123, 16'h0, 2'b00, 2'b00);
    chk_out("num1_0123", 16'h0123, 16'h0, 2'b00, 2'b00);

    do_reset();
    press(1, 0, 0, 4'd9, 2'd0, 1, 16'h0009, 16'h0, 2'b00, 2'b00);
    press(1, 0, 0, 4'd8, 2'd0, 1, 16'h0098, 16'h0, 2'b00, 2'b00);
    press(1, 0, 0, 4'd7, 2'd0, 1, 16'h0987, 16'h0, 2'b00, 2'b00);
    press(1, 0, 0, 4'd6, 2'd0, 1, 16'h9876, 16'h0, 2'b00, 2'b00);
    press(1, 0, 0, 4'd5, 2'd0, 0, 16'h0, 16'h0, 2'b00, 2'b00);
    chk_out("num1_full", 16'h9876, 16'h0, 2'b00, 2'b00);

    do_reset();
    press(1, 0, 0, 4'd4, 2'd0, 1, 16'h0004, 16'h0, 2'b00, 2'b00);
    press(0, 0, 1, 4'd0, 2'd0, 0, 16'h0, 16'h0, 2'b00, 2'b00);
    press(0, 1, 0, 4'd0, 2'b01, 1, 16'h0004, 16'h0, 2'b01, 2'b01);
    press(0, 1, 0, 4'd0, 2'b10, 1, 16'h0004, 16'h0, 2'b10, 2'b01);
    press(1, 0, 0, 4'd7, 2'd0, 1, 16'h0004, 16'h0007, 2'b10, 2'b10);
    press(0, 1, 0, 4'd0, 2'b11, 0, 16'h0, 16'h0, 2'b00, 2'b00);
    press(0, 0, 1, 4'd0, 2'd0, 1, 16'h0004, 16'h0007, 2'b10, 2'b11);
    chk_out("result_hold", 16'h0004, 16'h0007, 2'b10, 2'b11);
    press(0, 0, 1, 4'd0, 2'd0, 0, 16'h0, 16'h0, 2'b00, 2'b00);
    press(0, 1, 0, 4'd0, 2'b00, 1, 16'h0042, 16'h0, 2'b00, 2'b01);
    chk_out("chain_result", 16'h0042, 16'h0, 2'b00, 2'b01);
    press(1, 0, 0, 4'd3, 2'd0, 1, 16'h0042, 16'h0003, 2'b00, 2'b10);
    press(0, 0, 1, 4'd0, 2'd0, 1, 16'h0042, 16'h0003, 2'b00, 2'b11);
    press(1, 0, 0, 4'd5, 2'd0, 1, 16'h0005, 16'h0, 2'b00, 2'b00);
    press(1, 0, 0, 4'd6, 2'd0, 1, 16'h0056, 16'h0, 2'b00, 2'b00);
    chk_out("digit_after_result", 16'h0056, 16'h0, 2'b00, 2'b00);

    // held key across a mid-entry reset
    do_reset();
    @(negedge clk);
    is_num = 1'b1; num_val = 4'd6; btn_press = 1'b1;
    push_exp(16'h0006, 16'h0, 2'b00, 2'b00);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1 chk_out("async_reset", 16'h0, 16'h0, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk_out("held_after_reset", 16'h0, 16'h0, 2'b00, 2'b00);
    btn_press = 1'b0; is_num = 1'b0;
    repeat (2) @(negedge clk);
    press(1, 0, 0, 4'hA, 2'd0, 0, 16'h0, 16'h0, 2'b00, 2'b00);
    press(0, 0, 1, 4'd0, 2'd0, 0, 16'h0, 16'h0, 2'b00, 2'b00);
    chk_out("ignored_events", 16'h0, 16'h0, 2'b00, 2'b00);
    press(1, 0, 0, 4'd1, 2'd0, 1, 16'h0001, 16'h0, 2'b00, 2'b00);

    // idle behaviour after entering 5, op=01
    do_reset();
    press(1, 0, 0, 4'd5, 2'd0, 1, 16'h0005, 16'h0, 2'b00, 2'b00);
    @(negedge clk);
    is_op = 1'b1; op_val = 2'b01; btn_press = 1'b1;
    push_exp(16'h0005, 16'h0, 2'b01, 2'b01);
    @(negedge clk);
    btn_press = 1'b0; is_op = 1'b0;
`ifdef CALC_ENTRY_TIMEOUT_EN
    repeat (14) @(negedge clk);
    chk_out("before_timeout", 16'h0005, 16'h0, 2'b01, 2'b01);
    repeat (2) @(negedge clk);
    chk_out("after_timeout", 16'h0, 16'h0, 2'b00, 2'b00);
`else
    repeat (1000) @(negedge clk);
    chk_out("no_timeout", 16'h0005, 16'h0, 2'b01, 2'b01);
`endif

    repeat (3) @(negedge clk);
    chk("pending_acks", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Operand/operator entry controller between the keypad decoder (upstream) and the display multiplexor and ALU (downstream).
- Turns edge-detected key events into two 4-digit packed-BCD operands, an operation code and a 2-bit state code.
- Its outputs drive the display multiplexor and the combinational ALU. The ALU result is fed back so a result can be chained into a new operation.
- Runs on the low-frequency internal oscillator domain.

Parameters:
- NUM_DIGITS, 4, BCD digits per operand; operand width is 4*NUM_DIGITS = 16.
- TIMEOUT_CYCLES, 100000, idle clocks before auto-clear (only with CALC_ENTRY_TIMEOUT_EN); 10 s at 10 kHz.

Ports:
- clk  input  1  system clock (LF oscillator)
- rst  input  1  asynchronous, active-low reset
- btn_press  input  1  key held, from keypad decoder
- is_num  input  1  held key is a digit
- is_op  input  1  held key is an operator
- is_eq  input  1  held key is "="
- num_val  input  4  digit value, 0-9
- op_val  input  2  operator code
- alu_result  input  16  packed-BCD ALU output (num1 op num2)
- num1_bcd  output  16  first operand, packed BCD
- num2_bcd  output  16  second operand, packed BCD
- operation  output  2  latched operator code
- curr_state  output  2  00 NUM1, 01 OP, 10 NUM2, 11 RESULT
- key_ack  output  1  one-cycle pulse when a key event is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - num1_bcd=0, num2_bcd=0, operation=0, curr_state=00, key_ack=0.
  - Digit counters=0; btn_press history register=0.
- Event detect:
  - Internal btn_q <= btn_press every clock.
  - An event exists at a rising clk when btn_press=1 and btn_q=0.
  - Holding a key yields exactly one event. Release/re-press gives a new event.
- Classification priority: is_num > is_op > is_eq.
  - No flag set: event ignored.
  - is_num with num_val>9: event ignored.
  - Ignored events cause no state change and no key_ack.
- Latency: all outputs are registered and update on the same edge that detects the event, so they are visible one clock after btn_press rises. key_ack is high for exactly that one cycle.
- Digit entry: num <= {num[11:0], num_val}; digit count increments. At count==NUM_DIGITS, further digits are ignored (no ack). A leading 0 counts as a digit.
- NUM1 (00):
  - digit: shift into num1.
  - op: operation<=op_val, num2<=0, go OP. Allowed with zero digits entered, so num1=0.
  - eq: ignored.
- OP (01):
  - digit: num2<={12'h000,num_val}, count2=1, go NUM2.
  - op: replace operation, stay in OP (acked).
  - eq: ignored.
- NUM2 (10):
  - digit: shift into num2.
  - eq: go RESULT; operands are held so the ALU output stays valid.
  - op: ignored.
- RESULT (11):
  - digit: num1<={12'h000,num_val}, count1=1, num2<=0, operation<=0, go NUM1.
  - op: num1<=alu_result, count1=NUM_DIGITS, num2<=0, count2=0, operation<=op_val, go OP.
  - eq: ignored.
- Reset mid-entry: immediate return to reset values; a key still held at reset release produces no event until it is released and pressed again. btn_q resets to 0, but the first post-reset edge sees btn_press=1 and btn_q=0. To prevent a spurious event, btn_q also loads 1 on that cycle with no event when a hold-off flag (set by reset) is active; the hold-off flag clears once btn_press=0 is seen.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: CALC_ENTRY_TIMEOUT_EN.
- Defined:
  - A counter increments every clock and clears on any accepted event.
  - When it reaches TIMEOUT_CYCLES-1 while curr_state!=00 or count1!=0, all registers return to reset values on the next edge. key_ack stays 0 on that edge.
  - The counter saturates in the cleared NUM1 state.
- Undefined: no counter is present; entry persists indefinitely.

Test Plan:
- Reset, then press 1,2,3 (each held 3 cycles, released 2) -> num1_bcd=16'h0123, curr_state=00, three single-cycle key_ack pulses, each one clock after the btn_press rise.
- Press 9,8,7,6,5 -> num1_bcd=16'h9876, fifth digit produces no key_ack.
- Press 4, op=01, op=10, 7, "=" -> operation=2'b10, num2_bcd=16'h0007, state sequence 00,01,01,10,11.
- In RESULT with alu_result=16'h0042, press op=00 -> num1_bcd=16'h0042, num2_bcd=0, operation=00, state 01. Separately, press digit 5 in RESULT -> num1_bcd=16'h0005, state 00.
- Hold digit 6 for 20 cycles; assert rst=0 for 2 cycles during entry; press is_num with num_val=4'hA; press is_eq in NUM1 -> a single ack only for the held 6, all outputs zero after reset, and no change and no ack for the invalid digit or the eq.
- With CALC_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter 5, op=01, then idle -> all outputs 0 and state 00 after 16 cycles. Without the macro, the state is unchanged after 1000 cycles.
